// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART TX arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    // One bit time at 9600 baud from a 100 MHz clock.
    localparam int c_BAUD_DIV = 10416;
    localparam int c_DATA_W   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting at rr_ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return s[IDX_W-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        grant_valid  = 1'b0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_valid  = 1'b1;
                grant_idx    = wrap_idx(rr_ptr, k);
                grant_onehot = N_REQ'(1) << wrap_idx(rr_ptr, k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART byte transmitter among N_REQ
//            requesters, with start timeout and inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = c_DATA_W,
    parameter int START_TO   = 16,
    parameter int GAP_CYCLES = c_BAUD_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      arb_busy,
    output logic                      err_timeout
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(max_int(START_TO, GAP_CYCLES) + 1);

    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TO - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(N_REQ - 1);

    arb_state_t           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]     r_req_ready;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_tx_start;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic                 r_err_timeout;

    logic                 w_grant_valid;
    logic [N_REQ-1:0]     w_grant_onehot;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic [c_IDX_W-1:0]   w_next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req_valid    (req_valid),
        .rr_ptr       (r_rr_ptr),
        .grant_valid  (w_grant_valid),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    assign w_next_ptr = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_grant_id    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_req_ready   <= '0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (arb_enable && w_grant_valid) begin
                        r_tx_data   <= req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
                        r_grant_id  <= w_grant_idx;
                        r_req_ready <= w_grant_onehot;
                        r_rr_ptr    <= w_next_ptr;
                        r_tx_start  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= START;
                    end
                end
                START: begin
                    // Busy is checked first so it beats a coincident terminal count.
                    if (tx_busy) begin
                        r_tx_start <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= WAIT_DONE;
                    end else if (r_cnt == c_START_LAST) begin
                        r_tx_start    <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_cnt   <= '0;
                        r_state <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign grant_id    = r_grant_id;
    assign arb_busy    = (r_state != IDLE);
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    int          n_total = 0;
    int          n_bad   = 0;

    // Instance with a 4-cycle gap.
    logic        arb_enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        err_timeout;

    // Instance with no gap.
    logic        arb_enable_b;
    logic [3:0]  req_valid_b;
    logic [31:0] req_data_b;
    logic [3:0]  req_ready_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b;
    logic        tx_busy_b;
    logic [1:0]  grant_id_b;
    logic        arb_busy_b;
    logic        err_timeout_b;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TO(16), .GAP_CYCLES(c_GAP)) u_dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .START_TO(16), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .arb_enable(arb_enable_b), .req_valid(req_valid_b),
        .req_data(req_data_b), .req_ready(req_ready_b), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_busy(tx_busy_b), .grant_id(grant_id_b), .arb_busy(arb_busy_b), .err_timeout(err_timeout_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic await_grant(input string tag, input int exp_id, input logic [7:0] exp_data,
                               input int exp_lat);
        int lat;
        lat = 0;
        while (!tx_start && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_ready"}, req_ready, 32'(4'b0001 << exp_id));
        check_eq({tag, "_id"}, grant_id, exp_id);
        check_eq({tag, "_data"}, tx_data, exp_data);
    endtask

    task automatic finish_frame(input string tag, input int busy_len, input bit drop_en);
        int n;
        int noise;
        noise = 0;
        tick();
        check_eq({tag, "_ready_pulse"}, req_ready, 0);
        check_eq({tag, "_start_held"}, tx_start, 1);
        tx_busy = 1'b1;
        tick();
        check_eq({tag, "_start_drop"}, tx_start, 0);
        if (drop_en) arb_enable = 1'b0;
        for (int i = 0; i < busy_len; i++) begin
            tick();
            if (req_ready != 0 || tx_start) noise++;
        end
        tx_busy = 1'b0;
        n = 0;
        while (arb_busy && n < 50) begin
            tick();
            n++;
            if (req_ready != 0 || tx_start) noise++;
        end
        check_eq({tag, "_gap_len"}, n, c_GAP + 1);
        check_eq({tag, "_quiet"}, noise, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int errs;
        int quiet;

        reset        = 1'b1;
        arb_enable   = 1'b1;
        req_valid    = 4'b0000;
        req_data     = {8'h13, 8'h12, 8'h11, 8'h10};
        tx_busy      = 1'b0;
        arb_enable_b = 1'b1;
        req_valid_b  = 4'b0000;
        req_data_b   = {8'h23, 8'h22, 8'h21, 8'h20};
        tx_busy_b    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_start", tx_start, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_id", grant_id, 0);
        check_eq("rst_busy", arb_busy, 0);
        check_eq("rst_err", err_timeout, 0);
        #4 reset = 1'b0;
        tick();

        // Single request on lane 2.
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        await_grant("t1", 2, 8'hA5, 1);
        req_valid = 4'b0000;
        finish_frame("t1", 99, 0);
        check_eq("t1_hold_data", tx_data, 8'hA5);
        check_eq("t1_hold_id", grant_id, 2);

        // Round-robin from a fresh pointer.
        reset = 1'b1;
        #3 reset = 1'b0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            await_grant($sformatf("t2_f%0d", i), i % 4, 8'h10 + 8'(i % 4), 1);
            finish_frame($sformatf("t2_f%0d", i), 5, 0);
        end

        // Timeout: busy never rises, byte on lane 1 dropped, lane 2 next.
        req_valid = 4'b0110;
        await_grant("t3", 1, 8'h11, 1);
        n = 1;
        errs = 0;
        while (n < 40) begin
            tick();
            if (err_timeout) errs++;
            if (!tx_start) break;
            n++;
        end
        check_eq("t3_start_len", n, 16);
        check_eq("t3_err_pulse", err_timeout, 1);
        check_eq("t3_err_once", errs, 1);
        tick();
        check_eq("t3_err_clear", err_timeout, 0);
        await_grant("t3b", 2, 8'h12, 4);
        req_valid = 4'b0000;
        finish_frame("t3b", 5, 0);

        // Asynchronous reset in WAIT_DONE.
        req_valid = 4'b0010;
        await_grant("t4", 1, 8'h11, 1);
        req_valid = 4'b0000;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        check_eq("t4_rst_start", tx_start, 0);
        check_eq("t4_rst_data", tx_data, 0);
        check_eq("t4_rst_id", grant_id, 0);
        check_eq("t4_rst_busy", arb_busy, 0);
        check_eq("t4_rst_ready", req_ready, 0);
        check_eq("t4_rst_err", err_timeout, 0);
        tx_busy   = 1'b0;
        req_valid = 4'b0101;
        #2 reset = 1'b0;
        await_grant("t4r", 0, 8'h10, 1);
        req_valid = 4'b0000;
        finish_frame("t4r", 5, 0);

        // arb_enable dropped mid-frame with requests pending.
        req_valid = 4'b0110;
        await_grant("t5", 1, 8'h11, 1);
        finish_frame("t5", 10, 1);
        quiet = 0;
        repeat (10) begin
            tick();
            if (tx_start || req_ready != 0 || arb_busy) quiet++;
        end
        check_eq("t5_hold_idle", quiet, 0);
        arb_enable = 1'b1;
        await_grant("t5b", 2, 8'h12, 1);
        req_valid = 4'b0000;
        finish_frame("t5b", 5, 0);

        // Zero gap, back-to-back requests.
        req_valid_b = 4'b0011;
        n = 0;
        while (!tx_start_b && n < 40) begin
            tick();
            n++;
        end
        check_eq("t6_lat", n, 1);
        check_eq("t6_id0", grant_id_b, 0);
        check_eq("t6_data0", tx_data_b, 8'h20);
        tick();
        tx_busy_b = 1'b1;
        tick();
        check_eq("t6_start_drop", tx_start_b, 0);
        repeat (3) tick();
        tx_busy_b = 1'b0;
        tick();
        check_eq("t6_idle_next", arb_busy_b, 0);
        check_eq("t6_no_start_yet", tx_start_b, 0);
        tick();
        check_eq("t6_restart", tx_start_b, 1);
        check_eq("t6_id1", grant_id_b, 1);
        check_eq("t6_ready1", req_ready_b, 4'b0010);
        req_valid_b = 4'b0000;
        tick();
        tx_busy_b = 1'b1;
        tick();
        tx_busy_b = 1'b0;
        tick();
        check_eq("t6_final_idle", arb_busy_b, 0);
        check_eq("t6_no_err", err_timeout_b, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART byte transmitter between N_REQ requesters using round-robin arbitration. It accepts a byte from the granted requester and drives the transmitter's data/start handshake. It then tracks the transmitter's busy flag through the whole frame and enforces a programmable inter-frame gap. It sits between client logic (status reporters, command responders) and the 9600-baud TX serializer.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
START_TO, 16, max cycles tx_start is held waiting for tx_busy to rise before abort
GAP_CYCLES, 10416, idle cycles inserted after each frame (one bit time at 9600 baud from 100 MHz); 0 allowed

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
arb_enable  in  1  1 = new grants allowed; 0 = finish current frame, then hold in IDLE
req_valid  in  N_REQ  per-requester byte-pending flag
req_data  in  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-cycle pulse: byte of requester i captured
tx_data  out  DATA_W  byte presented to the transmitter
tx_start  out  1  transmit request to the transmitter
tx_busy  in  1  transmitter frame in progress (high start bit through stop bit)
grant_id  out  $clog2(N_REQ)  index of the requester currently being served
arb_busy  out  1  high whenever state != IDLE
err_timeout  out  1  one-cycle pulse when a start is aborted

Behaviour:
- Reset (async assert, sync-deassert-safe): state=IDLE; rr_ptr=0; req_ready=0; tx_data=0; tx_start=0; grant_id=0; err_timeout=0; counters=0. Reset mid-frame drops the byte with no ready/err pulse. tx_start falls immediately.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: if arb_enable && |req_valid:
  - Pick the first set req_valid bit, scanning from rr_ptr upward with wrap modulo N_REQ.
  - In the same edge: tx_data<=that byte, grant_id<=i, req_ready[i] pulses 1 cycle, rr_ptr<=(i+1) mod N_REQ, tx_start<=1, go START.
  - Grant latency: 1 cycle from req_valid sampled high.
- START: tx_start held high; start counter increments each cycle.
  - If tx_busy=1: tx_start<=0, go WAIT_DONE.
  - Else if counter reaches START_TO-1: tx_start<=0, err_timeout pulses, go GAP. Byte is dropped, not retried.
- WAIT_DONE: wait for tx_busy=0, then go GAP. If GAP_CYCLES=0, go IDLE directly.
- GAP: count GAP_CYCLES cycles with tx_start=0, then IDLE. Grants are never issued in GAP.
- tx_data and grant_id stay stable from capture until the next grant.
- Requesters may drop req_valid at any time before their grant. A dropped request is simply not selected. Changes to req_valid/req_data after req_ready do not affect the frame in flight.
- arb_enable deasserted mid-frame: the frame and gap complete normally. IDLE then holds with no grants.
- Fairness: with all N_REQ requesting continuously, each gets exactly one grant per N_REQ frames.
- Simultaneous tx_busy rise and timeout terminal count in START: busy wins (no error).
- All counters are sized $clog2(max(START_TO, GAP_CYCLES)+1) and never wrap in operation.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, WAIT_DONE, GAP), default baud divisor constant 10416, DATA_W=8.
- One sub-module, rr_arbiter: a combinational round-robin pick of req_valid relative to rr_ptr, returning a grant one-hot and index. The FSM, counters and registers stay in the top module.

Test Plan:
1. Single request: req_valid=4'b0100, data 8'hA5; TX model raises busy 2 cycles after start for 100 cycles -> req_ready[2] one pulse, tx_data=A5, grant_id=2, tx_start high exactly 2 cycles, arb_busy low GAP_CYCLES cycles after busy falls.
2. Round-robin: all four valid continuously with bytes 10/11/12/13, GAP_CYCLES=4 -> grant order 0,1,2,3,0 with tx_data 10,11,12,13,10 and no requester served twice in any window of 4.
3. Timeout: TX model never raises busy, START_TO=16 -> tx_start high 16 cycles, err_timeout one pulse, next grant goes to the following requester after the gap.
4. Reset mid-frame: assert reset during WAIT_DONE -> all outputs 0 asynchronously. After release with req_valid=4'b0001, rr_ptr=0 and requester 0 is granted.
5. arb_enable=0 asserted in WAIT_DONE with requests pending -> current frame and gap complete, no further req_ready until arb_enable=1. The next grant then occurs 1 cycle later.
6. GAP_CYCLES=0 with back-to-back requests -> IDLE is re-entered the cycle after busy falls, and the next tx_start asserts the following cycle.
